// File: rtl/if_stage_fetch_if.sv
// Instruction-memory request/ack bus between the fetch stage and instruction memory.
interface if_stage_fetch_if #(
  parameter int unsigned WORD_WIDTH = 32
);
  logic                  imem_req;
  logic [WORD_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [WORD_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: holds the fetch PC, issues req/ack word fetches and
// presents each instruction with its PC+step to decode through a registered
// IF/ID slot backed by a one-entry skid buffer.
module if_stage_fetch #(
  parameter int unsigned           WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [WORD_WIDTH-1:0] branch_address,
  if_stage_fetch_if.master      imem,
  output logic [WORD_WIDTH-1:0] pc,
  output logic [WORD_WIDTH-1:0] instruction,
  output logic                  valid
);

  // StReq=0, StFull=1, StDrop=2; value 3 is unreachable and falls back to StReq.
  typedef enum logic [1:0] {
    StReq  = 2'd0,
    StFull = 2'd1,
    StDrop = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_WIDTH-1:0] redirect_q, redirect_d;
  logic [WORD_WIDTH-1:0] skid_q, skid_d;
  logic [WORD_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [WORD_WIDTH-1:0] pc_q, pc_d;
  logic [WORD_WIDTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;

  logic                  slot_free;
  logic [WORD_WIDTH-1:0] fetch_pc_next;

  assign slot_free     = ~valid_q | ~freeze;
  assign fetch_pc_next = fetch_pc_q + WORD_WIDTH'(PC_STEP);

  // Request depends only on state and reset, so freeze/branch never reach the memory port.
  assign imem.imem_req  = rst & ((state_q == StReq) | (state_q == StDrop));
  assign imem.imem_addr = fetch_pc_q;

  assign pc          = pc_q;
  assign instruction = instr_q;
  assign valid       = valid_q;

  // Next-state, fetch PC, skid buffer and IF/ID slot update.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    redirect_d = redirect_q;
    skid_d     = skid_q;
    skid_pc_d  = skid_pc_q;
    // A free slot with nothing loading turns into a bubble; an occupied frozen slot holds.
    if (slot_free) begin
      pc_d    = '0;
      instr_d = '0;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
    end

    case (state_q)
      StReq: begin
        if (branch_taken) begin
          pc_d    = '0;
          instr_d = '0;
          valid_d = 1'b0;
          if (imem.imem_ack) begin
            fetch_pc_d = branch_address;
          end else begin
            // Keep the outstanding request stable; its data is dropped on arrival.
            redirect_d = branch_address;
            state_d    = StDrop;
          end
        end else if (imem.imem_ack) begin
          fetch_pc_d = fetch_pc_next;
          if (slot_free) begin
            pc_d    = fetch_pc_next;
            instr_d = imem.imem_rdata;
            valid_d = 1'b1;
          end else begin
            skid_d    = imem.imem_rdata;
            skid_pc_d = fetch_pc_next;
            state_d   = StFull;
          end
        end
      end
      StFull: begin
        if (branch_taken) begin
          pc_d       = '0;
          instr_d    = '0;
          valid_d    = 1'b0;
          fetch_pc_d = branch_address;
          state_d    = StReq;
        end else if (!freeze) begin
          pc_d    = skid_pc_q;
          instr_d = skid_q;
          valid_d = 1'b1;
          state_d = StReq;
        end
      end
      StDrop: begin
        pc_d    = '0;
        instr_d = '0;
        valid_d = 1'b0;
        if (imem.imem_ack) begin
          fetch_pc_d = branch_taken ? branch_address : redirect_q;
          state_d    = StReq;
        end else if (branch_taken) begin
          redirect_d = branch_address;
        end
      end
      default: begin
        state_d = StReq;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StReq;
      fetch_pc_q <= RESET_PC;
      redirect_q <= '0;
      skid_q     <= '0;
      skid_pc_q  <= '0;
      pc_q       <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      redirect_q <= redirect_d;
      skid_q     <= skid_d;
      skid_pc_q  <= skid_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Testbench for if_stage_fetch: scoreboarded streaming, cycle-vector table for
// freeze/branch corner cases, and PC wrap plus asynchronous reset on a second instance.
module tb_if_stage_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_address = '0;
  logic [31:0] pc, instruction;
  logic        valid;

  logic        freeze2 = 1'b0;
  logic        branch2 = 1'b0;
  logic [31:0] baddr2 = '0;
  logic [31:0] pc2, instruction2;
  logic        valid2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_stage_fetch_if #(.WORD_WIDTH(32)) bus1 ();
  if_stage_fetch_if #(.WORD_WIDTH(32)) bus2 ();

  if_stage_fetch #(.WORD_WIDTH(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .imem           (bus1),
    .pc             (pc),
    .instruction    (instruction),
    .valid          (valid)
  );

  if_stage_fetch #(.WORD_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze2),
    .branch_taken   (branch2),
    .branch_address (baddr2),
    .imem           (bus2),
    .pc             (pc2),
    .instruction    (instruction2),
    .valid          (valid2)
  );

  typedef struct {
    logic        f;
    logic        b;
    logic [31:0] ba;
    logic        ack;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  vec_t tbl[22];
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic f, input logic b, input logic [31:0] ba,
                              input logic ack, input logic [31:0] rd, input logic e_req,
                              input logic [31:0] e_addr, input logic e_v,
                              input logic [31:0] e_pc, input logic [31:0] e_ins);
    vec_t v;
    v.f = f; v.b = b; v.ba = ba; v.ack = ack; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc; v.e_ins = e_ins;
    return v;
  endfunction

  initial begin
    logic [31:0] exp_addr;
    exp_t        e;

    // Corner-case vectors, starting from a fresh reset (fetch_pc=0, slot empty).
    // Freeze with skid
    tbl[0]  = mk(0, 0, 0,        1, 32'hA000_0000, 1, 32'h0,   1, 32'h4,   32'hA000_0000);
    tbl[1]  = mk(0, 0, 0,        1, 32'hA000_0001, 1, 32'h4,   1, 32'h8,   32'hA000_0001);
    tbl[2]  = mk(1, 0, 0,        1, 32'hA000_0002, 1, 32'h8,   1, 32'h8,   32'hA000_0001);
    tbl[3]  = mk(1, 0, 0,        0, 32'h0,         0, 32'h0,   1, 32'h8,   32'hA000_0001);
    tbl[4]  = mk(0, 0, 0,        0, 32'h0,         0, 32'h0,   1, 32'hC,   32'hA000_0002);
    tbl[5]  = mk(0, 0, 0,        1, 32'hA000_0003, 1, 32'hC,   1, 32'h10,  32'hA000_0003);
    // Branch with ack
    tbl[6]  = mk(0, 0, 0,        0, 32'h0,         1, 32'h10,  0, 32'h0,   32'h0);
    tbl[7]  = mk(0, 1, 32'h100,  1, 32'hDEAD_BEEF, 1, 32'h10,  0, 32'h0,   32'h0);
    tbl[8]  = mk(0, 0, 0,        1, 32'hB000_0000, 1, 32'h100, 1, 32'h104, 32'hB000_0000);
    // Branch mid-request, second redirect wins
    tbl[9]  = mk(0, 0, 0,        0, 32'h0,         1, 32'h104, 0, 32'h0,   32'h0);
    tbl[10] = mk(0, 1, 32'h200,  0, 32'h0,         1, 32'h104, 0, 32'h0,   32'h0);
    tbl[11] = mk(0, 0, 0,        0, 32'h0,         1, 32'h104, 0, 32'h0,   32'h0);
    tbl[12] = mk(0, 1, 32'h300,  0, 32'h0,         1, 32'h104, 0, 32'h0,   32'h0);
    tbl[13] = mk(0, 0, 0,        1, 32'hDEAD_BEEF, 1, 32'h104, 0, 32'h0,   32'h0);
    tbl[14] = mk(0, 0, 0,        1, 32'hC000_0000, 1, 32'h300, 1, 32'h304, 32'hC000_0000);
    // Branch under freeze while skid is full
    tbl[15] = mk(1, 0, 0,        1, 32'hC000_0001, 1, 32'h304, 1, 32'h304, 32'hC000_0000);
    tbl[16] = mk(1, 1, 32'h80,   0, 32'h0,         0, 32'h0,   0, 32'h0,   32'h0);
    tbl[17] = mk(1, 0, 0,        1, 32'hD000_0000, 1, 32'h80,  1, 32'h84,  32'hD000_0000);
    tbl[18] = mk(0, 0, 0,        0, 32'h0,         1, 32'h84,  0, 32'h0,   32'h0);
    // Drop state with same-cycle branch and ack
    tbl[19] = mk(0, 1, 32'h400,  0, 32'h0,         1, 32'h84,  0, 32'h0,   32'h0);
    tbl[20] = mk(0, 1, 32'h500,  1, 32'hDEAD_BEEF, 1, 32'h84,  0, 32'h0,   32'h0);
    tbl[21] = mk(0, 0, 0,        1, 32'hE500_0000, 1, 32'h500, 1, 32'h504, 32'hE500_0000);

    bus1.imem_ack = 1'b0; bus1.imem_rdata = '0;
    bus2.imem_ack = 1'b0; bus2.imem_rdata = '0;

    // Reset state
    #2;
    chk("reset_valid", {31'b0, valid}, 32'h0);
    chk("reset_pc", pc, 32'h0);
    chk("reset_instr", instruction, 32'h0);
    chk("reset_req", {31'b0, bus1.imem_req}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release_req", {31'b0, bus1.imem_req}, 32'h1);
    chk("release_addr", bus1.imem_addr, 32'h0);

    // Streaming with an ack every cycle
    exp_addr = 32'h0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      bus1.imem_ack   = 1'b1;
      bus1.imem_rdata = 32'hE000_0000 + 32'(n);
      #1;
      chk("stream_addr", bus1.imem_addr, exp_addr);
      e.pc  = exp_addr + 32'h4;
      e.ins = bus1.imem_rdata;
      sbq.push_back(e);
      exp_addr = exp_addr + 32'h4;
      @(posedge clk);
      #1;
      chk("stream_valid", {31'b0, valid}, 32'h1);
      if (valid && sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("stream_pc", pc, e.pc);
        chk("stream_instr", instruction, e.ins);
      end
    end
    chk("stream_sb_empty", 32'(sbq.size()), 32'h0);

    // Clean restart for the vector table
    @(negedge clk);
    bus1.imem_ack = 1'b0;
    rst = 1'b0;
    #1;
    chk("restart_valid", {31'b0, valid}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      freeze          = tbl[i].f;
      branch_taken    = tbl[i].b;
      branch_address  = tbl[i].ba;
      bus1.imem_ack   = tbl[i].ack;
      bus1.imem_rdata = tbl[i].rd;
      #1;
      chk($sformatf("vec%0d_req", i), {31'b0, bus1.imem_req}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("vec%0d_addr", i), bus1.imem_addr, tbl[i].e_addr);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), {31'b0, valid}, {31'b0, tbl[i].e_v});
      chk($sformatf("vec%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("vec%0d_instr", i), instruction, tbl[i].e_ins);
    end

    // PC wrap on the instance reset to 0xFFFFFFFC
    @(negedge clk);
    freeze = 1'b0; branch_taken = 1'b0; branch_address = '0;
    bus1.imem_ack = 1'b0;
    bus2.imem_ack = 1'b1;
    bus2.imem_rdata = 32'hF000_0000;
    #1;
    chk("wrap_req", {31'b0, bus2.imem_req}, 32'h1);
    chk("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    chk("wrap_valid", {31'b0, valid2}, 32'h1);
    chk("wrap_pc", pc2, 32'h0);
    chk("wrap_instr", instruction2, 32'hF000_0000);
    @(negedge clk);
    bus2.imem_ack = 1'b0;
    #1;
    chk("wrap_addr1", bus2.imem_addr, 32'h0);

    // Asynchronous reset in the middle of an outstanding request
    #2;
    rst = 1'b0;
    #1;
    chk("areset_req", {31'b0, bus2.imem_req}, 32'h0);
    chk("areset_valid", {31'b0, valid2}, 32'h0);
    chk("areset_pc", pc2, 32'h0);
    chk("areset_instr", instruction2, 32'h0);
    chk("areset_req1", {31'b0, bus1.imem_req}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("restart_req", {31'b0, bus2.imem_req}, 32'h1);
    chk("restart_addr", bus2.imem_addr, 32'hFFFF_FFFC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage_fetch.md
Name: if_stage_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the decode stage.
- Holds the architectural fetch PC and issues word fetches over a req/ack instruction-memory port.
- Delivers each instruction with its PC+4 to decode through a registered IF/ID output slot, backed by a one-entry skid buffer.
- Honours the hazard freeze from decode and branch redirects/flushes from execute.

Parameters:
WORD_WIDTH, 32, width of PC, addresses and instruction words
RESET_PC, 0, fetch address after reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low
freeze  input  1  decode stall; IF/ID output slot must hold
branch_taken  input  1  redirect/flush request from execute
branch_address  input  WORD_WIDTH  redirect target, valid with branch_taken
imem_req  output  1  fetch request
imem_addr  output  WORD_WIDTH  fetch byte address
imem_ack  input  1  single-cycle completion pulse; imem_rdata valid this cycle
imem_rdata  input  WORD_WIDTH  fetched instruction
pc  output  WORD_WIDTH  fetched address + PC_STEP (to decode pc_in)
instruction  output  WORD_WIDTH  fetched word (to decode instruction_in)
valid  output  1  pc/instruction hold a real instruction; 0 = bubble

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC; state=S_REQ.
  - pc=0, instruction=0, valid=0.
  - Skid buffer empty.
  - imem_req rises combinationally from S_REQ once rst deasserts.
- Memory protocol:
  - imem_req=1 and imem_addr=fetch_pc in S_REQ and S_DROP. imem_req=0 in S_FULL.
  - Once imem_req is raised, req and addr stay constant until a cycle with imem_ack=1.
  - Ack may come in the same cycle req rises (zero-wait memory). Minimum latency is 1 cycle from fetch_pc to a valid output.
- Output slot "free" means valid=0 or freeze=0. On any clock edge where the slot is free and no new data loads, it becomes a bubble: valid=0, instruction=0, pc=0. When freeze=1 and valid=1, pc/instruction/valid hold.
- S_REQ (precedence in this order):
  - branch_taken=1 and imem_ack=1: discard rdata; fetch_pc<=branch_address; flush slot to bubble; stay S_REQ.
  - branch_taken=1 and imem_ack=0: flush slot; redirect<=branch_address; go S_DROP. imem_addr stays at the old fetch_pc.
  - imem_ack=1 and slot free: instruction<=imem_rdata, pc<=fetch_pc+PC_STEP, valid<=1, fetch_pc<=fetch_pc+PC_STEP; stay S_REQ. This gives back-to-back fetches.
  - imem_ack=1 and slot not free: skid<=rdata, skid_pc<=fetch_pc+PC_STEP; fetch_pc advances; go S_FULL.
- S_FULL (imem_req=0):
  - branch_taken=1: drop skid; flush slot; fetch_pc<=branch_address; go S_REQ.
  - freeze=0: move skid into the output slot with valid=1; go S_REQ.
  - Otherwise: hold.
- S_DROP (old request outstanding, result must be discarded):
  - branch_taken=1 again: redirect<=new branch_address. The latest target wins.
  - imem_ack=1: discard rdata; fetch_pc<=redirect (or the same-cycle branch_address); go S_REQ.
  - Slot remains a bubble throughout.
- Priority: branch_taken over freeze, always. A flush clears valid even when freeze=1.
- Arithmetic: PC addition is modulo 2^WORD_WIDTH. 0xFFFFFFFC+4 wraps to 0 with no flag.
- Asynchronous reset mid-request abandons the request; memory must tolerate req dropping without ack.
- State encoding: 2 bits, S_REQ=0, S_FULL=1, S_DROP=2. Value 3 is unreachable and recovers to S_REQ.
- No combinational path exists from freeze or branch_taken to imem_req or imem_addr.

Test Plan:
- Reset/stream: release rst, ack every cycle with rdata=0xE0000000+n -> addrs 0,4,8,12; outputs pc=4,8,12,16, valid=1 from cycle 2, instruction matches each fetch.
- Freeze with skid: freeze=1 while valid=1 and ack arrives for addr 8 -> output holds pc=8; imem_req drops; freeze=0 -> pc=12 loaded from skid next cycle; fetch resumes at addr 12.
- Branch with ack: branch_taken=1, branch_address=0x100 in the same cycle as ack for addr 0x20 -> valid=0 next cycle; rdata discarded; next imem_addr=0x100; first output pc=0x104.
- Branch mid-request: ack delayed 3 cycles on addr 0x40, branch to 0x200 in cycle 1 -> imem_addr stays 0x40 until ack; ack data dropped; then addr=0x200, valid=0 throughout.
- Branch under freeze: freeze=1, valid=1, state S_FULL, branch_taken=1 to 0x80 -> valid=0, skid dropped, next addr 0x80.
- Wrap and async reset: RESET_PC=0xFFFFFFFC -> second fetch addr 0; assert rst mid-wait -> outputs zero immediately, imem_req=0 asynchronously, restart at RESET_PC.
